// File: rtl/corevx_ptw_pkg.sv
// Shared types and constants for the corevx Sv32 page-table walker.
package corevx_ptw_pkg;

    localparam int unsigned VPN_W     = 20;
    localparam int unsigned VPN_SEG_W = 10;
    localparam int unsigned PPN_W     = 22;
    localparam int unsigned PTE_W     = 32;
    localparam int unsigned ADDR_W    = 34;
    localparam int unsigned TAG_WIDTH = 8;
    localparam int unsigned RESP_W    = 2;
    localparam int unsigned TMO_CNT_W = 8;

    // Accesstag bit positions, shared with the cache TLB entry layout (PTE[7:0])
    localparam int unsigned ATAG_V = 0;
    localparam int unsigned ATAG_R = 1;
    localparam int unsigned ATAG_W = 2;
    localparam int unsigned ATAG_X = 3;
    localparam int unsigned ATAG_U = 4;
    localparam int unsigned ATAG_G = 5;
    localparam int unsigned ATAG_A = 6;
    localparam int unsigned ATAG_D = 7;

    localparam int unsigned PTE_RSW_LSB  = 8;
    localparam int unsigned PTE_RSW_MSB  = 9;
    localparam int unsigned PTE_PPN0_LSB = 10;
    localparam int unsigned PTE_PPN0_MSB = 19;
    localparam int unsigned PTE_PPN1_LSB = 20;
    localparam int unsigned PTE_PPN1_MSB = 31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } ptw_state_e;

    typedef enum logic [RESP_W-1:0] {
        AVL_RESP_OKAY     = 2'b00,
        AVL_RESP_RESERVED = 2'b01,
        AVL_RESP_SLVERR   = 2'b10,
        AVL_RESP_DECERR   = 2'b11
    } avl_resp_e;

    typedef struct packed {
        logic                 pagefault;
        logic                 accessfault;
        logic [PPN_W-1:0]     ppn;
        logic [TAG_WIDTH-1:0] access_bits;
    } ptw_result_t;

    function automatic logic [ADDR_W-1:0] pte_addr(input logic [PPN_W-1:0]     table_ppn,
                                                   input logic [VPN_SEG_W-1:0] vpn_seg);
        return {table_ppn, vpn_seg, 2'b00};
    endfunction

endpackage

// File: rtl/corevx_ptw_pte_decode.sv
// Combinational Sv32 PTE classifier used by the walker at each level.
module corevx_ptw_pte_decode
    import corevx_ptw_pkg::*;
(
    input  logic [PTE_W-1:0] pte,
    input  logic             level,
    output logic             is_leaf,
    output logic             is_invalid,
    output logic             misaligned,
    output logic [PPN_W-1:0] next_ppn
);

    logic unused_pte_bits;

    assign is_invalid = !pte[ATAG_V] || (pte[ATAG_W] && !pte[ATAG_R]);
    assign is_leaf    = pte[ATAG_R] || pte[ATAG_X];
    // A megapage leaf must have PPN0 clear so the 4 MiB region is naturally aligned
    assign misaligned = level && (pte[PTE_PPN0_MSB:PTE_PPN0_LSB] != '0);
    assign next_ppn   = pte[PTE_PPN1_MSB:PTE_PPN0_LSB];

    // U/G/A/D and RSW only pass through to the downstream permission check
    assign unused_pte_bits = ^{pte[ATAG_U], pte[ATAG_G], pte[ATAG_A], pte[ATAG_D],
                               pte[PTE_RSW_MSB:PTE_RSW_LSB]};

endmodule

// File: rtl/corevx_ptw.sv
// Sv32 hardware page-table walker: up to two PTE reads over Avalon-MM, returns leaf PPN + accesstag.
// Optional read timeout enabled by defining COREVX_PTW_TIMEOUT_EN.
module corevx_ptw
    import corevx_ptw_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 resolve_request,
    output logic                 resolve_ack,
    input  logic [VPN_W-1:0]     resolve_virtual_address,
    input  logic [PPN_W-1:0]     satp_ppn,
    output logic                 resolve_done,
    output logic                 resolve_pagefault,
    output logic                 resolve_accessfault,
    output logic [PPN_W-1:0]     resolve_physical_address,
    output logic [TAG_WIDTH-1:0] resolve_access_bits,
    output logic [ADDR_W-1:0]    avl_address,
    output logic                 avl_read,
    input  logic                 avl_waitrequest,
    input  logic                 avl_readdatavalid,
    input  logic [PTE_W-1:0]     avl_readdata,
    input  logic [RESP_W-1:0]    avl_response
);

    ptw_state_e           state_q, state_d;
    logic [VPN_W-1:0]     vpn_q, vpn_d;
    logic [PPN_W-1:0]     table_ppn_q, table_ppn_d;
    logic                 level_q, level_d;
    ptw_result_t          result_q, result_d;
    logic                 done_q, done_d;
    logic                 ack_q, ack_d;
    logic                 read_q, read_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
`ifdef COREVX_PTW_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    logic                 unused_timeout_cycles;
    assign unused_timeout_cycles = ^TMO_CNT_W'(TIMEOUT_CYCLES);
`endif

    logic                 pte_is_leaf;
    logic                 pte_is_invalid;
    logic                 pte_misaligned;
    logic [PPN_W-1:0]     pte_next_ppn;
    logic [VPN_SEG_W-1:0] vpn_seg_d;

    corevx_ptw_pte_decode u_pte_decode (
        .pte        (avl_readdata),
        .level      (level_q),
        .is_leaf    (pte_is_leaf),
        .is_invalid (pte_is_invalid),
        .misaligned (pte_misaligned),
        .next_ppn   (pte_next_ppn)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        vpn_d       = vpn_q;
        table_ppn_d = table_ppn_q;
        level_d     = level_q;
        result_d    = '0;
        ack_d       = 1'b0;
`ifdef COREVX_PTW_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (resolve_request) begin
                    ack_d       = 1'b1;
                    vpn_d       = resolve_virtual_address;
                    table_ppn_d = satp_ppn;
                    level_d     = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!avl_waitrequest) begin
                    state_d = ST_WAIT;
`ifdef COREVX_PTW_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (avl_readdatavalid) begin
                    state_d = ST_DONE;
                    if (avl_resp_e'(avl_response) != AVL_RESP_OKAY) begin
                        result_d.accessfault = 1'b1;
                    end else if (pte_is_invalid) begin
                        result_d.pagefault   = 1'b1;
                        result_d.access_bits = avl_readdata[TAG_WIDTH-1:0];
                    end else if (pte_is_leaf) begin
                        result_d.access_bits = avl_readdata[TAG_WIDTH-1:0];
                        if (pte_misaligned) begin
                            result_d.pagefault = 1'b1;
                        end else if (level_q) begin
                            result_d.ppn = {avl_readdata[PTE_PPN1_MSB:PTE_PPN1_LSB],
                                            vpn_q[VPN_SEG_W-1:0]};
                        end else begin
                            result_d.ppn = pte_next_ppn;
                        end
                    end else if (level_q) begin
                        table_ppn_d = pte_next_ppn;
                        level_d     = 1'b0;
                        state_d     = ST_ISSUE;
                    end else begin
                        result_d.pagefault   = 1'b1;
                        result_d.access_bits = avl_readdata[TAG_WIDTH-1:0];
                    end
                end
`ifdef COREVX_PTW_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d              = ST_DONE;
                    result_d.accessfault = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus outputs track the state being entered so they are flop-driven yet aligned with it
        vpn_seg_d = level_d ? vpn_d[VPN_W-1:VPN_SEG_W] : vpn_d[VPN_SEG_W-1:0];
        done_d    = (state_d == ST_DONE);
        read_d    = (state_d == ST_ISSUE);
        addr_d    = read_d ? pte_addr(table_ppn_d, vpn_seg_d) : addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vpn_q       <= '0;
            table_ppn_q <= '0;
            level_q     <= 1'b0;
            result_q    <= '0;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
            read_q      <= 1'b0;
            addr_q      <= '0;
`ifdef COREVX_PTW_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            vpn_q       <= vpn_d;
            table_ppn_q <= table_ppn_d;
            level_q     <= level_d;
            result_q    <= result_d;
            done_q      <= done_d;
            ack_q       <= ack_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
`ifdef COREVX_PTW_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign resolve_ack              = ack_q;
    assign resolve_done             = done_q;
    assign resolve_pagefault        = result_q.pagefault;
    assign resolve_accessfault      = result_q.accessfault;
    assign resolve_physical_address = result_q.ppn;
    assign resolve_access_bits      = result_q.access_bits;
    assign avl_read                 = read_q;
    assign avl_address              = addr_q;

endmodule

// File: tb/tb_corevx_ptw.sv
// Scoreboard bench for corevx_ptw: Avalon memory model, expected addresses/results queued at request time.
module tb_corevx_ptw;

    typedef struct {
        logic        pf;
        logic        af;
        logic [21:0] pa;
        logic [7:0]  bits;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        resolve_request = 1'b0;
    logic        resolve_ack;
    logic [19:0] resolve_virtual_address = '0;
    logic [21:0] satp_ppn = '0;
    logic        resolve_done;
    logic        resolve_pagefault;
    logic        resolve_accessfault;
    logic [21:0] resolve_physical_address;
    logic [7:0]  resolve_access_bits;
    logic [33:0] avl_address;
    logic        avl_read;
    logic        avl_waitrequest = 1'b0;
    logic        avl_readdatavalid = 1'b0;
    logic [31:0] avl_readdata = '0;
    logic [1:0]  avl_response = '0;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          req_cyc = 0;
    bit          done_seen = 1'b0;

    logic [31:0] mem [logic [33:0]];
    logic [33:0] addr_q [$];
    exp_t        exp_q [$];
    exp_t        mon_e;
    bit          err_en = 1'b0;
    logic [33:0] err_addr = '0;
    int          stall_left = 0;
    bit          drop_rdv = 1'b0;
    bit          force_rdv = 1'b0;
    bit          resp_pending = 1'b0;
    logic [33:0] resp_addr = '0;

    corevx_ptw #(.TIMEOUT_CYCLES(16)) u_dut (
        .clk                      (clk),
        .rst                      (rst),
        .resolve_request          (resolve_request),
        .resolve_ack              (resolve_ack),
        .resolve_virtual_address  (resolve_virtual_address),
        .satp_ppn                 (satp_ppn),
        .resolve_done             (resolve_done),
        .resolve_pagefault        (resolve_pagefault),
        .resolve_accessfault      (resolve_accessfault),
        .resolve_physical_address (resolve_physical_address),
        .resolve_access_bits      (resolve_access_bits),
        .avl_address              (avl_address),
        .avl_read                 (avl_read),
        .avl_waitrequest          (avl_waitrequest),
        .avl_readdatavalid        (avl_readdatavalid),
        .avl_readdata             (avl_readdata),
        .avl_response             (avl_response)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic pf, input logic af, input logic [21:0] pa,
                                input logic [7:0] bits, input int lat);
        exp_t e;
        e.pf = pf; e.af = af; e.pa = pa; e.bits = bits; e.lat = lat;
        return e;
    endfunction

    // Reference Sv32 walk over the memory model; queues the PTE addresses it expects on the bus
    task automatic predict(input logic [21:0] satp, input logic [19:0] vpn, input int stall,
                           output exp_t e);
        logic [21:0] tp;
        logic        lvl;
        logic [33:0] a;
        logic [31:0] pte;
        int          reads;
        e = mk(1'b0, 1'b0, 22'h0, 8'h0, 0);
        tp = satp; lvl = 1'b1; reads = 0;
        for (int step = 0; step < 2; step++) begin
            a = {tp, (lvl ? vpn[19:10] : vpn[9:0]), 2'b00};
            addr_q.push_back(a);
            reads++;
            pte = mem.exists(a) ? mem[a] : 32'h0;
            if (err_en && a == err_addr) begin
                e.af = 1'b1; break;
            end
            if (!pte[0] || (pte[2] && !pte[1])) begin
                e.pf = 1'b1; e.bits = pte[7:0]; break;
            end
            if (pte[1] || pte[3]) begin
                e.bits = pte[7:0];
                if (lvl && pte[19:10] != 10'h0) e.pf = 1'b1;
                else e.pa = lvl ? {pte[31:20], vpn[9:0]} : pte[31:10];
                break;
            end
            if (!lvl) begin
                e.pf = 1'b1; e.bits = pte[7:0]; break;
            end
            tp = pte[31:10]; lvl = 1'b0;
        end
        e.lat = 2 + 2 * reads + stall;
    endtask

    // Avalon slave: fixed read latency of one cycle after acceptance, optional stall / drop
    always @(negedge clk) begin
        avl_readdatavalid = 1'b0;
        avl_readdata      = 32'h0;
        avl_response      = 2'b00;
        if (resp_pending) begin
            resp_pending      = 1'b0;
            avl_readdatavalid = 1'b1;
            avl_readdata      = mem.exists(resp_addr) ? mem[resp_addr] : 32'h0;
            avl_response      = (err_en && resp_addr == err_addr) ? 2'b10 : 2'b00;
        end
        if (force_rdv) begin
            force_rdv         = 1'b0;
            avl_readdatavalid = 1'b1;
            avl_readdata      = 32'h4000000F;
        end
        avl_waitrequest = 1'b0;
        if (!rst && avl_read) begin
            if (addr_q.size() == 0) begin
                chk("rd_extra", 64'(addr_q.size()), 64'd1);
            end else begin
                chk("rd_addr", 64'(avl_address), 64'(addr_q[0]));
            end
            if (stall_left > 0) begin
                avl_waitrequest = 1'b1;
                stall_left--;
            end else begin
                if (addr_q.size() != 0) void'(addr_q.pop_front());
                if (!drop_rdv) begin
                    resp_pending = 1'b1;
                    resp_addr    = avl_address;
                end
            end
        end
    end

    // Result monitor: pops the scoreboard on every resolve_done
    always @(negedge clk) begin
        if (!rst && resolve_done) begin
            if (exp_q.size() == 0) begin
                chk("done_extra", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_pf",   64'(resolve_pagefault),        64'(mon_e.pf));
                chk("done_af",   64'(resolve_accessfault),      64'(mon_e.af));
                chk("done_pa",   64'(resolve_physical_address), 64'(mon_e.pa));
                chk("done_bits", 64'(resolve_access_bits),      64'(mon_e.bits));
                chk("done_lat",  64'(cyc - req_cyc + 1),        64'(mon_e.lat));
            end
            done_seen = 1'b1;
        end
    end

    task automatic walk(input logic [21:0] satp, input logic [19:0] vpn, input int stall,
                        input bit drop, input bit use_lit, input exp_t lit);
        exp_t e;
        predict(satp, vpn, stall, e);
        exp_q.push_back(use_lit ? lit : e);
        stall_left = stall;
        drop_rdv   = drop;
        done_seen  = 1'b0;
        @(negedge clk);
        resolve_request         = 1'b1;
        resolve_virtual_address = vpn;
        satp_ppn                = satp;
        req_cyc                 = cyc;
        @(negedge clk);
        chk("ack", 64'(resolve_ack), 64'd1);
        @(negedge clk);
        chk("ack_busy", 64'(resolve_ack), 64'd0);
        resolve_request = 1'b0;
        for (int i = 0; i < 200 && !done_seen; i++) @(posedge clk);
        chk("done_seen", 64'(done_seen), 64'd1);
        @(negedge clk);
        chk("done_pulse", 64'(resolve_done), 64'd0);
        chk("rd_left", 64'(addr_q.size()), 64'd0);
        addr_q.delete();
        exp_q.delete();
        drop_rdv = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_addr"}, 64'(avl_address), 64'd0);
        chk({tag, "_ctl"}, 64'({avl_read, resolve_ack, resolve_done,
                                resolve_pagefault, resolve_accessfault}), 64'd0);
        chk({tag, "_res"}, 64'({resolve_physical_address, resolve_access_bits}), 64'd0);
    endtask

    task automatic reset_mid_walk();
        exp_t e;
        predict(22'h00010, 20'h00123, 0, e);
        drop_rdv = 1'b1;
        @(negedge clk);
        resolve_request         = 1'b1;
        resolve_virtual_address = 20'h00123;
        satp_ppn                = 22'h00010;
        @(negedge clk);
        resolve_request = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("rst_wait");
        rst      = 1'b0;
        drop_rdv = 1'b0;
        @(posedge clk);
        force_rdv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_rdv", 64'({avl_read, resolve_ack, resolve_done,
                                 resolve_pagefault, resolve_accessfault}), 64'd0);
        end
        chk("rst_rd_left", 64'(addr_q.size()), 64'd0);
        addr_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        logic [21:0] s;
        logic [19:0] v;
        logic [33:0] a1;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 4 KiB page, two reads
        mem[34'h0_0001_0004] = 32'h00008001;
        mem[34'h0_0002_0004] = 32'h123450CF;
        walk(22'h00010, 20'h00401, 0, 1'b0, 1'b1, mk(1'b0, 1'b0, 22'h048D14, 8'hCF, 6));

        // Aligned megapage
        mem[34'h0_0001_0000] = 32'h4000000F;
        walk(22'h00010, 20'h00123, 0, 1'b0, 1'b1, mk(1'b0, 1'b0, 22'h100123, 8'h0F, 4));

        // Misaligned megapage
        mem[34'h0_0001_1000] = 32'h40000C0F;
        walk(22'h00011, 20'h00123, 0, 1'b0, 1'b1, mk(1'b1, 1'b0, 22'h0, 8'h0F, 4));

        // Invalid PTE (V=0, W without R)
        mem[34'h0_0001_2000] = 32'h00000004;
        walk(22'h00012, 20'h00000, 0, 1'b0, 1'b1, mk(1'b1, 1'b0, 22'h0, 8'h04, 4));

        // Non-leaf at level 0
        mem[34'h0_0001_3004] = 32'h00008001;
        mem[34'h0_0002_0008] = 32'h00008001;
        walk(22'h00013, 20'h00402, 0, 1'b0, 1'b1, mk(1'b1, 1'b0, 22'h0, 8'h01, 6));

        // Bus error on first read
        mem[34'h0_0001_4000] = 32'h4000000F;
        err_en   = 1'b1;
        err_addr = 34'h0_0001_4000;
        walk(22'h00014, 20'h00000, 0, 1'b0, 1'b1, mk(1'b0, 1'b1, 22'h0, 8'h00, 4));
        err_en   = 1'b0;

        // Five stalled cycles on the only read
        walk(22'h00010, 20'h00123, 5, 1'b0, 1'b1, mk(1'b0, 1'b0, 22'h100123, 8'h0F, 9));

        reset_mid_walk();
        walk(22'h00010, 20'h00123, 0, 1'b0, 1'b1, mk(1'b0, 1'b0, 22'h100123, 8'h0F, 4));

`ifdef COREVX_PTW_TIMEOUT_EN
        // No read data: 1 request + 1 issue + 16 wait + 1 done cycles
        walk(22'h00010, 20'h00123, 0, 1'b1, 1'b1, mk(1'b0, 1'b1, 22'h0, 8'h00, 19));
`endif

        // Random walks checked against the reference model
        for (int n = 0; n < 24; n++) begin
            s  = {2'b11, 20'($urandom)};
            v  = 20'($urandom);
            a1 = {s, v[19:10], 2'b00};
            p  = $urandom;
            case ($urandom_range(0, 3))
                0: p[3:0] = 4'b0001;
                1: begin p[19:10] = 10'h0; p[1:0] = 2'b11; end
                2: p[3:0] = 4'b1001;
                default: ;
            endcase
            mem[a1] = p;
            if (p[3:0] == 4'b0001) begin
                mem[{p[31:10], v[9:0], 2'b00}] = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                               : {32'($urandom) & 32'hFFFF_FCF0} | 32'h0000_000B;
            end
            walk(s, v, int'($urandom_range(0, 2)), 1'b0, 1'b0, mk(1'b0, 1'b0, 22'h0, 8'h0, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
